regincr_pipe: RTL

Parametrised, elastic register-increment pipeline. Each message enters through a val/rdy input interface and passes through `p_nstages` register stages. Every stage adds `p_incr` to the message, and the result leaves through a val/rdy output interface. It generalises the fixed single-register incrementer with configurable width, depth, increment and overflow mode. It also adds per-stage flow control, so it can sit between any two latency-insensitive blocks in the datapath.

---
 rtl/regincr_pipe.sv | 107 ++++++++++
 1 files changed

// File: rtl/regincr_pipe.sv
// regincr_pipe: elastic multi-stage register-increment pipeline.
// Each stage adds p_incr to the message it loads and keeps a sticky overflow
// flag. Every stage has its own val/rdy handshake, so an empty stage always
// accepts from upstream and bubbles collapse. Wrap or saturate on overflow.
module regincr_pipe #(
  parameter int p_nbits   = 8,
  parameter int p_nstages = 2,
  parameter int p_incr    = 1,
  parameter int p_sat     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_ovf
);

  localparam int               last  = p_nstages - 1;
  localparam logic [p_nbits:0] incr  = (p_nbits + 1)'(p_incr);

  // Per-stage state.
  logic [p_nstages-1:0] val;
  logic [p_nstages-1:0] ovf;
  logic [p_nbits-1:0]   msg [p_nstages];

  // Per-stage control and datapath.
  logic [p_nstages-1:0] go;
  logic [p_nstages-1:0] ld;
  logic [p_nbits-1:0]   src_msg [p_nstages];
  logic [p_nstages-1:0] src_ovf;
  logic [p_nbits:0]     sum     [p_nstages];
  logic [p_nbits-1:0]   nxt_msg [p_nstages];
  logic [p_nstages-1:0] nxt_ovf;

  // Flow control: advance from the output backwards, then derive loads.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (that would infer a latch).
    go = '0;
    ld = '0;
    go[last] = val[last] & out_rdy;
    for (int k = last - 1; k >= 0; k--) begin
      go[k] = val[k] & (~val[k+1] | go[k+1]);
    end
    in_rdy = ~val[0] | go[0];
    ld[0]  = in_val & in_rdy;
    for (int k = 1; k <= last; k++) begin
      ld[k] = go[k-1];
    end
  end

  // Increment datapath: select each stage's source, add, wrap or clamp.
  always_comb begin
    src_ovf = '0;
    nxt_ovf = '0;
    for (int k = 0; k <= last; k++) begin
      if (k == 0) begin
        src_msg[k] = in_msg;
        src_ovf[k] = 1'b0;
      end else begin
        src_msg[k] = msg[k-1];
        src_ovf[k] = ovf[k-1];
      end
      sum[k] = {1'b0, src_msg[k]} + incr;
      if ((p_sat != 0) && sum[k][p_nbits]) begin
        nxt_msg[k] = '1;
      end else begin
        nxt_msg[k] = sum[k][p_nbits-1:0];
      end
      nxt_ovf[k] = src_ovf[k] | sum[k][p_nbits];
    end
  end

  // Stage registers: load new data, drain to empty, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the message registers are cleared too, not just the valids,
      // because out_msg/out_ovf must read zero while reset is asserted.
      val <= '0;
      ovf <= '0;
      for (int k = 0; k <= last; k++) begin
        msg[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the values
      // its neighbours held before this edge.
      for (int k = 0; k <= last; k++) begin
        if (ld[k]) begin
          val[k] <= 1'b1;
          msg[k] <= nxt_msg[k];
          ovf[k] <= nxt_ovf[k];
        end else if (go[k]) begin
          val[k] <= 1'b0;
        end
      end
    end
  end

  assign out_val = val[last];
  assign out_msg = msg[last];
  assign out_ovf = ovf[last];

endmodule
